sound_ram_arbiter: RTL and testbench

//  Shares the single 64 KB sound RAM between the DOC5503 wavetable fetch port and the host (sound GLU) port.

---
 rtl/sound_ram_pkg.sv | 18 +
 rtl/sound_ram_arbiter.sv | 162 ++++++++++++++++
 tb/tb_sound_ram_arbiter.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sound_ram_pkg.sv
// Shared types and constants for the sound RAM arbiter between the DOC5503
// wavetable fetch port and the sound GLU host port.
package sound_ram_pkg;

   localparam int SND_ADDR_W = 16;
   localparam int SND_DATA_W = 8;

   localparam logic [SND_DATA_W-1:0] ABORT_SAMPLE_DEFAULT = 8'h80;
   localparam logic [SND_DATA_W-1:0] HOST_ABORT_DATA      = 8'hFF;

   typedef enum logic [1:0] {
      IDLE,
      DOC_RD,
      HOST_RD,
      HOST_WR
   } arb_state_t;

endpackage

// File: rtl/sound_ram_arbiter.sv
// Arbitrates the 64 KB sound RAM between DOC wave fetches (priority, with a
// bounded streak) and host accesses, aborting transactions on a stalled RAM.
module sound_ram_arbiter
   import sound_ram_pkg::*;
#(
   parameter int                    MAX_DOC_STREAK = 4,
   parameter int                    TIMEOUT_CYCLES = 64,
   parameter logic [SND_DATA_W-1:0] ABORT_SAMPLE   = ABORT_SAMPLE_DEFAULT
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic [SND_ADDR_W-1:0] doc_addr_i,
   input  logic                  doc_rd_i,
   output logic                  doc_ready_o,
   output logic [SND_DATA_W-1:0] doc_data_o,
   input  logic                  host_req_i,
   input  logic                  host_we_i,
   input  logic [SND_ADDR_W-1:0] host_addr_i,
   input  logic [SND_DATA_W-1:0] host_wdata_i,
   output logic                  host_ack_o,
   output logic [SND_DATA_W-1:0] host_rdata_o,
   output logic [SND_ADDR_W-1:0] mem_addr_o,
   output logic                  mem_rd_o,
   output logic                  mem_wr_o,
   output logic [SND_DATA_W-1:0] mem_wdata_o,
   input  logic                  mem_ready_i,
   input  logic [SND_DATA_W-1:0] mem_rdata_i,
   output logic                  busy_o,
   output logic                  doc_overrun_o,
   output logic                  timeout_err_o
);

   localparam int STREAK_W = $clog2(MAX_DOC_STREAK + 1);
   localparam int TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DOC_STREAK);
   localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);

   arb_state_t state_q, state_d;

   logic                  doc_pend_q;
   logic [SND_ADDR_W-1:0] doc_addr_q;
   logic [STREAK_W-1:0]   streak_q;
   logic [TMO_W-1:0]      tmo_cnt_q;
   logic                  first_q;
   logic [SND_ADDR_W-1:0] mem_addr_q;
   logic [SND_DATA_W-1:0] mem_wdata_q;

   logic doc_accept, doc_req, host_starved;
   logic grant_doc, grant_host;
   logic done_ok, done_abort;

   // A strobe is accepted only when nothing from the DOC is pending or in
   // flight; a fresh strobe competes in IDLE the same cycle it arrives.
   always_comb begin
      doc_accept   = doc_rd_i && !doc_pend_q;
      doc_req      = doc_pend_q || doc_accept;
      host_starved = host_req_i && (streak_q == STREAK_MAX);
      done_ok      = (state_q != IDLE) && mem_ready_i;
      done_abort   = (state_q != IDLE) && !mem_ready_i && (tmo_cnt_q == TMO_LAST);
   end

   // NOTE: state_d takes a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (doc_req && !host_starved) state_d = DOC_RD;
            else if (host_req_i)          state_d = host_we_i ? HOST_WR : HOST_RD;
         end
         default: begin
            if (done_ok || done_abort) state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      grant_doc  = (state_q == IDLE) && (state_d == DOC_RD);
      grant_host = (state_q == IDLE) && (state_d == HOST_RD || state_d == HOST_WR);
   end

   // NOTE: all clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (reset_i) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Output decode: strobes last exactly the first cycle of a transaction.
   always_comb begin
      busy_o      = (state_q != IDLE);
      mem_rd_o    = first_q && (state_q == DOC_RD || state_q == HOST_RD);
      mem_wr_o    = first_q && (state_q == HOST_WR);
      mem_addr_o  = mem_addr_q;
      mem_wdata_o = mem_wdata_q;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         doc_pend_q    <= 1'b0;
         doc_addr_q    <= '0;
         streak_q      <= '0;
         tmo_cnt_q     <= '0;
         first_q       <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         doc_ready_o   <= 1'b0;
         doc_data_o    <= '0;
         host_ack_o    <= 1'b0;
         host_rdata_o  <= '0;
         doc_overrun_o <= 1'b0;
         timeout_err_o <= 1'b0;
      end else begin
         doc_ready_o <= 1'b0;
         host_ack_o  <= 1'b0;
         first_q     <= 1'b0;

         if (doc_rd_i && doc_pend_q) doc_overrun_o <= 1'b1;
         if (doc_accept) begin
            doc_pend_q <= 1'b1;
            doc_addr_q <= doc_addr_i;
         end

         if (state_q != IDLE) tmo_cnt_q <= tmo_cnt_q + 1'b1;

         if (grant_doc) begin
            mem_addr_q <= doc_pend_q ? doc_addr_q : doc_addr_i;
            tmo_cnt_q  <= '0;
            first_q    <= 1'b1;
            if (streak_q != STREAK_MAX) streak_q <= streak_q + 1'b1;
         end
         if (grant_host) begin
            mem_addr_q  <= host_addr_i;
            mem_wdata_q <= host_wdata_i;
            tmo_cnt_q   <= '0;
            first_q     <= 1'b1;
            streak_q    <= '0;
         end

         if (done_ok || done_abort) begin
            unique case (state_q)
               DOC_RD: begin
                  doc_ready_o <= 1'b1;
                  doc_data_o  <= done_ok ? mem_rdata_i : ABORT_SAMPLE;
                  doc_pend_q  <= 1'b0;
               end
               HOST_RD: begin
                  host_ack_o   <= 1'b1;
                  host_rdata_o <= done_ok ? mem_rdata_i : HOST_ABORT_DATA;
               end
               HOST_WR: begin
                  host_ack_o <= 1'b1;
                  if (done_abort) host_rdata_o <= HOST_ABORT_DATA;
               end
               default: ;
            endcase
         end
         if (done_abort) timeout_err_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sound_ram_arbiter.sv
// Scoreboard bench for sound_ram_arbiter: directed stimulus pushes expected
// RAM strobes and DOC/host responses; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_sound_ram_arbiter;
   import sound_ram_pkg::*;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic [15:0] doc_addr_i = '0;
   logic        doc_rd_i = 1'b0;
   logic        doc_ready_o;
   logic [7:0]  doc_data_o;
   logic        host_req_i = 1'b0;
   logic        host_we_i = 1'b0;
   logic [15:0] host_addr_i = '0;
   logic [7:0]  host_wdata_i = '0;
   logic        host_ack_o;
   logic [7:0]  host_rdata_o;
   logic [15:0] mem_addr_o;
   logic        mem_rd_o;
   logic        mem_wr_o;
   logic [7:0]  mem_wdata_o;
   logic        mem_ready_i = 1'b0;
   logic [7:0]  mem_rdata_i = '0;
   logic        busy_o;
   logic        doc_overrun_o;
   logic        timeout_err_o;

   sound_ram_arbiter dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .doc_addr_i(doc_addr_i), .doc_rd_i(doc_rd_i),
      .doc_ready_o(doc_ready_o), .doc_data_o(doc_data_o),
      .host_req_i(host_req_i), .host_we_i(host_we_i),
      .host_addr_i(host_addr_i), .host_wdata_i(host_wdata_i),
      .host_ack_o(host_ack_o), .host_rdata_o(host_rdata_o),
      .mem_addr_o(mem_addr_o), .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o),
      .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i),
      .mem_rdata_i(mem_rdata_i), .busy_o(busy_o),
      .doc_overrun_o(doc_overrun_o), .timeout_err_o(timeout_err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct { logic wr; logic [15:0] addr; logic [7:0] wdata; } mem_exp_t;
   typedef struct { logic chk; logic [7:0] data; } host_exp_t;

   mem_exp_t  mem_q[$];
   logic [7:0] doc_q[$];
   host_exp_t host_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int t_strobe = 0, t_doc_rdy = 0, t_host_ack = 0;

   logic [7:0] ram [0:65535];
   int         ram_lat = 2;
   logic       stall = 1'b0;
   int         rsp_cnt = 0;
   logic [7:0] rsp_data = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clk_i) cyc <= cyc + 1;

   // RAM model: ready pulse ram_lat cycles after the strobe unless stalled.
   always @(negedge clk_i) begin
      mem_ready_i = 1'b0;
      if (reset_i) begin
         rsp_cnt = 0;
      end else begin
         if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
               mem_ready_i = 1'b1;
               mem_rdata_i = rsp_data;
            end
         end
         if ((mem_rd_o || mem_wr_o) && !stall) begin
            if (mem_wr_o) ram[mem_addr_o] = mem_wdata_o;
            rsp_data = ram[mem_addr_o];
            rsp_cnt  = ram_lat;
         end
      end
   end

   mem_exp_t  mon_m;
   logic [7:0] mon_d;
   host_exp_t mon_h;

   always @(negedge clk_i) begin
      if (!reset_i) begin
         if (mem_rd_o || mem_wr_o) begin
            t_strobe = cyc;
            check("mem_strobe_expected", 64'(mem_q.size() != 0), 64'd1);
            if (mem_q.size() != 0) begin
               mon_m = mem_q.pop_front();
               check("mem_wr", 64'(mem_wr_o), 64'(mon_m.wr));
               check("mem_rd", 64'(mem_rd_o), 64'(!mon_m.wr));
               check("mem_addr", 64'(mem_addr_o), 64'(mon_m.addr));
               if (mon_m.wr) check("mem_wdata", 64'(mem_wdata_o), 64'(mon_m.wdata));
            end
         end
         if (doc_ready_o) begin
            t_doc_rdy = cyc;
            check("doc_ready_expected", 64'(doc_q.size() != 0), 64'd1);
            if (doc_q.size() != 0) begin
               mon_d = doc_q.pop_front();
               check("doc_data", 64'(doc_data_o), 64'(mon_d));
            end
         end
         if (host_ack_o) begin
            t_host_ack = cyc;
            check("host_ack_expected", 64'(host_q.size() != 0), 64'd1);
            if (host_q.size() != 0) begin
               mon_h = host_q.pop_front();
               if (mon_h.chk) check("host_rdata", 64'(host_rdata_o), 64'(mon_h.data));
            end
         end
      end
   end

   function automatic logic [63:0] all_outputs();
      return 64'({doc_ready_o, doc_data_o, host_ack_o, host_rdata_o, mem_addr_o,
                  mem_rd_o, mem_wr_o, mem_wdata_o, busy_o, doc_overrun_o, timeout_err_o});
   endfunction

   task automatic push_mem(input logic wr, input logic [15:0] a, input logic [7:0] d);
      mem_exp_t e;
      e.wr = wr; e.addr = a; e.wdata = d;
      mem_q.push_back(e);
   endtask

   task automatic push_host(input logic chk, input logic [7:0] d);
      host_exp_t e;
      e.chk = chk; e.data = d;
      host_q.push_back(e);
   endtask

   task automatic start_doc(input logic [15:0] a);
      doc_addr_i = a;
      doc_rd_i   = 1'b1;
   endtask

   task automatic start_host(input logic we, input logic [15:0] a, input logic [7:0] d);
      host_we_i    = we;
      host_addr_i  = a;
      host_wdata_i = d;
      host_req_i   = 1'b1;
   endtask

   // Runs until every expectation is consumed; drops strobes and the host request.
   task automatic drain(input string name);
      int n = 0;
      while ((mem_q.size() + doc_q.size() + host_q.size()) != 0 && n < 500) begin
         @(negedge clk_i);
         n++;
         doc_rd_i = 1'b0;
         if (host_ack_o) host_req_i = 1'b0;
      end
      check({name, "_drained"}, 64'(mem_q.size() + doc_q.size() + host_q.size()), 64'd0);
      repeat (2) @(negedge clk_i);
      if (host_ack_o) host_req_i = 1'b0;
      check({name, "_idle"}, 64'(busy_o), 64'd0);
   endtask

   // Host read held while the DOC re-strobes in each of its ack cycles.
   task automatic run_streak();
      int docs = 1;
      int n = 0;
      @(negedge clk_i);
      start_host(1'b0, 16'h0200, 8'h00);
      start_doc(16'h3000);
      while ((host_req_i || docs < 5) && n < 300) begin
         @(negedge clk_i);
         n++;
         doc_rd_i = 1'b0;
         if (host_ack_o) host_req_i = 1'b0;
         if (doc_ready_o && docs < 5) begin
            start_doc(16'h3000 + 16'(docs));
            docs++;
         end
      end
      check("streak_loop_bound", 64'(n < 300), 64'd1);
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ram[16'h1234] = 8'h5A;
      ram[16'h1111] = 8'h21;
      ram[16'h0200] = 8'h77;
      for (int i = 0; i < 5; i++) ram[16'h3000 + i] = 8'h10 + 8'(i);

      repeat (3) @(negedge clk_i);
      check("reset_outputs", all_outputs(), 64'd0);
      reset_i = 1'b0;
      @(negedge clk_i);
      check("post_reset_outputs", all_outputs(), 64'd0);

      // 1: DOC-only fetch with 2-cycle RAM
      ram_lat = 2;
      push_mem(1'b0, 16'h1234, 8'h00);
      doc_q.push_back(8'h5A);
      start_doc(16'h1234);
      drain("t1");
      check("t1_strobe_to_ready", 64'(t_doc_rdy - t_strobe), 64'd3);

      // 2: host write then read back, 1-cycle RAM (minimum latency)
      ram_lat = 1;
      push_mem(1'b1, 16'h0100, 8'hC3);
      push_host(1'b0, 8'h00);
      start_host(1'b1, 16'h0100, 8'hC3);
      drain("t2w");
      check("t2_min_strobe_to_ack", 64'(t_host_ack - t_strobe), 64'd2);
      push_mem(1'b0, 16'h0100, 8'h00);
      push_host(1'b1, 8'hC3);
      start_host(1'b0, 16'h0100, 8'h00);
      drain("t2r");

      // 3: simultaneous requests, DOC wins first
      push_mem(1'b0, 16'h1111, 8'h00);
      push_mem(1'b0, 16'h0100, 8'h00);
      doc_q.push_back(8'h21);
      push_host(1'b1, 8'hC3);
      start_doc(16'h1111);
      start_host(1'b0, 16'h0100, 8'h00);
      drain("t3");

      // 4: four DOC grants, then the starved host, then the fifth DOC
      for (int i = 0; i < 4; i++) begin
         push_mem(1'b0, 16'h3000 + 16'(i), 8'h00);
         doc_q.push_back(8'h10 + 8'(i));
      end
      push_mem(1'b0, 16'h0200, 8'h00);
      push_host(1'b1, 8'h77);
      push_mem(1'b0, 16'h3004, 8'h00);
      doc_q.push_back(8'h14);
      run_streak();
      drain("t4");
      check("t4_no_overrun", 64'(doc_overrun_o), 64'd0);
      check("t4_no_timeout", 64'(timeout_err_o), 64'd0);

      // 5: stalled RAM, DOC abort then host read abort
      stall = 1'b1;
      push_mem(1'b0, 16'h4000, 8'h00);
      doc_q.push_back(8'h80);
      start_doc(16'h4000);
      drain("t5d");
      check("t5_abort_latency", 64'(t_doc_rdy - t_strobe), 64'd64);
      check("t5_timeout_err", 64'(timeout_err_o), 64'd1);
      push_mem(1'b0, 16'h0200, 8'h00);
      push_host(1'b1, 8'hFF);
      start_host(1'b0, 16'h0200, 8'h00);
      drain("t5h");
      stall = 1'b0;

      // 6: dropped strobe during DOC_RD, then reset during a host read
      ram_lat = 2;
      push_mem(1'b0, 16'h1234, 8'h00);
      doc_q.push_back(8'h5A);
      start_doc(16'h1234);
      @(negedge clk_i);
      doc_rd_i = 1'b0;
      @(negedge clk_i);
      start_doc(16'h5555);
      drain("t6d");
      check("t6_overrun", 64'(doc_overrun_o), 64'd1);
      ram_lat = 5;
      push_mem(1'b0, 16'h0200, 8'h00);
      start_host(1'b0, 16'h0200, 8'h00);
      repeat (2) @(negedge clk_i);
      check("t6_host_in_flight", 64'(busy_o), 64'd1);
      reset_i    = 1'b1;
      host_req_i = 1'b0;
      repeat (3) @(negedge clk_i);
      check("t6_reset_outputs", all_outputs(), 64'd0);
      reset_i = 1'b0;
      repeat (10) @(negedge clk_i);
      check("t6_after_reset_outputs", all_outputs(), 64'd0);
      check("t6_strobe_consumed", 64'(mem_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
